load_store_unit: RTL and testbench

//  Requester-side master for the word-only DataMem wrapper (Mem). It accepts

---
 rtl/load_store_unit_pkg.sv | 34 +++
 rtl/load_store_unit_lane_align.sv | 46 ++++
 rtl/load_store_unit.sv | 116 +++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, access-size classes and
// the alignment rule used at request accept.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    WRITE,
    RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } lsu_size_e;

  // Both 2'b10 and 2'b11 on the request bus mean byte.
  function automatic lsu_size_e decode_size(input logic [1:0] size);
    if (size[1])      return SZ_BYTE;
    else if (size[0]) return SZ_HALF;
    else              return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (decode_size(size))
      SZ_WORD: return lane != 2'b00;
      SZ_HALF: return lane[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic shared by loads (extract + extend) and sub-word
// stores (merge new lane into the word read from memory). Little-endian.
module lane_align
  import load_store_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  lsu_size_e     size,
  input  logic [1:0]    addr,
  input  logic          uns,
  input  logic [DW-1:0] word,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [4:0]  byte_off;
  logic [4:0]  half_off;

  assign byte_off  = {addr, 3'b000};
  assign half_off  = {addr[1], 4'b0000};
  assign byte_lane = word[byte_off +: 8];
  assign half_lane = word[half_off +: 16];

  always_comb begin
    rdata  = '0;
    merged = word;
    case (size)
      SZ_WORD: begin
        rdata  = word;
        merged = wdata;
      end
      SZ_HALF: begin
        rdata                 = {{(DW-16){~uns & half_lane[15]}}, half_lane};
        merged[half_off +: 16] = wdata[15:0];
      end
      default: begin
        rdata                 = {{(DW-8){~uns & byte_lane[7]}}, byte_lane};
        merged[byte_off +: 8] = wdata[7:0];
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Requester-side master for the word-only data memory: byte/half/word loads
// and stores, sub-word stores done as read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic          resp_err,
  output logic [DW-1:0] resp_rdata,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  lsu_state_e    state;
  lsu_size_e     lat_size;
  logic          lat_we;
  logic          lat_uns;
  logic [1:0]    lat_lane;
  logic [DW-1:0] lat_wdata;

  logic [DW-1:0] align_rdata;
  logic [DW-1:0] align_merged;

  assign req_ready = (state == IDLE);

  lane_align #(.DW(DW)) u_lane_align (
    .size   (lat_size),
    .addr   (lat_lane),
    .uns    (lat_uns),
    .word   (mem_rdata),
    .wdata  (lat_wdata),
    .rdata  (align_rdata),
    .merged (align_merged)
  );

  // Word stores skip the read phase and drive the write straight from the
  // accepted request; every other access goes through READ/CAPT first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_size   <= SZ_WORD;
      lat_we     <= 1'b0;
      lat_uns    <= 1'b0;
      lat_lane   <= '0;
      lat_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_size  <= decode_size(req_size);
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_lane  <= req_addr[1:0];
            lat_wdata <= req_wdata;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && decode_size(req_size) == SZ_WORD) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= req_addr[AW-1:2];
              mem_wdata <= req_wdata;
            end else begin
              state    <= READ;
              mem_addr <= req_addr[AW-1:2];
            end
          end
        end
        READ: state <= CAPT;
        CAPT: begin
          if (lat_we) begin
            state     <= WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= align_merged;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= align_rdata;
          end
        end
        WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a 1-cycle-latency word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } resp_t;

  resp_t exp_q[$];
  resp_t obs_q[$];

  int vectors = 0;
  int miscompares = 0;
  int we_pulses = 0;

  always #5 clk = ~clk;

  load_store_unit #(.AW(8), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) if (mem_we) we_pulses++;

  task automatic lsu_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    resp_t e;
    resp_t o;
    int guard;
    e.err = exp_err; e.rdata = exp_rdata; e.lat = exp_lat;
    exp_q.push_back(e);
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    o.err = 1'bx; o.rdata = 'x; o.lat = -1;
    for (int n = 1; n <= 12; n++) begin
      if (resp_valid) begin
        o.err = resp_err; o.rdata = resp_rdata; o.lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready/rv/err/we=%b want 1000", {req_ready, resp_valid, resp_err, mem_we});
    end
    vectors++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 70'd0) begin
      miscompares++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want 0", resp_rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_word();
    lsu_op(1'b1, 2'b00, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
    lsu_op(1'b0, 2'b00, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3);
    while (exp_q.size() != 0) begin
      resp_t e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      vectors++;
      if ({o.err, o.rdata, o.lat} !== {e.err, e.rdata, e.lat}) begin
        miscompares++;
        $display("FAIL word: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d", o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
      end
    end
  endtask

  task automatic test_byte_load();
    lsu_op(1'b1, 2'b00, 1'b0, 8'h20, 32'h11223344, 1'b0, 32'h0, 2);
    lsu_op(1'b0, 2'b10, 1'b0, 8'h21, 32'h0, 1'b0, 32'h00000033, 3);
    lsu_op(1'b1, 2'b00, 1'b0, 8'h20, 32'h80FF7F00, 1'b0, 32'h0, 2);
    lsu_op(1'b0, 2'b10, 1'b0, 8'h22, 32'h0, 1'b0, 32'hFFFFFFFF, 3);
    lsu_op(1'b0, 2'b11, 1'b1, 8'h23, 32'h0, 1'b0, 32'h00000080, 3);
    lsu_op(1'b0, 2'b10, 1'b0, 8'h23, 32'h0, 1'b0, 32'hFFFFFF80, 3);
    lsu_op(1'b0, 2'b10, 1'b0, 8'h21, 32'h0, 1'b0, 32'h0000007F, 3);
    while (exp_q.size() != 0) begin
      resp_t e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      vectors++;
      if ({o.err, o.rdata, o.lat} !== {e.err, e.rdata, e.lat}) begin
        miscompares++;
        $display("FAIL byte_load: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d", o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
      end
    end
  endtask

  task automatic test_half_load();
    lsu_op(1'b0, 2'b01, 1'b0, 8'h22, 32'h0, 1'b0, 32'hFFFF80FF, 3);
    lsu_op(1'b0, 2'b01, 1'b1, 8'h20, 32'h0, 1'b0, 32'h00007F00, 3);
    lsu_op(1'b0, 2'b01, 1'b1, 8'h22, 32'h0, 1'b0, 32'h000080FF, 3);
    while (exp_q.size() != 0) begin
      resp_t e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      vectors++;
      if ({o.err, o.rdata, o.lat} !== {e.err, e.rdata, e.lat}) begin
        miscompares++;
        $display("FAIL half_load: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d", o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
      end
    end
  endtask

  task automatic test_subword_store();
    int p0;
    lsu_op(1'b1, 2'b00, 1'b0, 8'h30, 32'h11223344, 1'b0, 32'h0, 2);
    p0 = we_pulses;
    lsu_op(1'b1, 2'b10, 1'b0, 8'h31, 32'hFFFFFFAA, 1'b0, 32'h0, 4);
    vectors++;
    if (mem[12] !== 32'h1122AA44 || we_pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL byte_store: got word=%h pulses=%0d want 1122aa44 pulses=1", mem[12], we_pulses - p0);
    end
    p0 = we_pulses;
    lsu_op(1'b1, 2'b01, 1'b0, 8'h32, 32'h0000BEEF, 1'b0, 32'h0, 4);
    vectors++;
    if (mem[12] !== 32'hBEEFAA44 || we_pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL half_store: got word=%h pulses=%0d want beefaa44 pulses=1", mem[12], we_pulses - p0);
    end
    lsu_op(1'b0, 2'b00, 1'b0, 8'h30, 32'h0, 1'b0, 32'hBEEFAA44, 3);
    while (exp_q.size() != 0) begin
      resp_t e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      vectors++;
      if ({o.err, o.rdata, o.lat} !== {e.err, e.rdata, e.lat}) begin
        miscompares++;
        $display("FAIL subword_store: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d", o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
      end
    end
  endtask

  task automatic test_misaligned();
    int p0;
    lsu_op(1'b1, 2'b00, 1'b0, 8'h04, 32'hCAFEF00D, 1'b0, 32'h0, 2);
    p0 = we_pulses;
    lsu_op(1'b0, 2'b01, 1'b0, 8'h01, 32'h0, 1'b1, 32'h0, 1);
    lsu_op(1'b1, 2'b00, 1'b0, 8'h06, 32'h12345678, 1'b1, 32'h0, 1);
    lsu_op(1'b1, 2'b01, 1'b0, 8'h05, 32'h00001234, 1'b1, 32'h0, 1);
    vectors++;
    if (mem[1] !== 32'hCAFEF00D || we_pulses != p0) begin
      miscompares++;
      $display("FAIL misaligned_mem: got word=%h pulses=%0d want cafef00d pulses=0", mem[1], we_pulses - p0);
    end
    while (exp_q.size() != 0) begin
      resp_t e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      vectors++;
      if ({o.err, o.rdata, o.lat} !== {e.err, e.rdata, e.lat}) begin
        miscompares++;
        $display("FAIL misaligned: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d", o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    lsu_op(1'b1, 2'b00, 1'b0, 8'h40, 32'h0BADF00D, 1'b0, 32'h0, 2);
    lsu_op(1'b0, 2'b10, 1'b1, 8'h43, 32'h0, 1'b0, 32'h0000000B, 3);
    lsu_op(1'b1, 2'b01, 1'b0, 8'h40, 32'hFFFF1234, 1'b0, 32'h0, 4);
    lsu_op(1'b0, 2'b00, 1'b0, 8'h40, 32'h0, 1'b0, 32'h0BAD1234, 3);
    lsu_op(1'b1, 2'b10, 1'b0, 8'h40, 32'h000000EE, 1'b0, 32'h0, 4);
    lsu_op(1'b0, 2'b00, 1'b0, 8'h40, 32'h0, 1'b0, 32'h0BAD12EE, 3);
    while (exp_q.size() != 0) begin
      resp_t e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      vectors++;
      if ({o.err, o.rdata, o.lat} !== {e.err, e.rdata, e.lat}) begin
        miscompares++;
        $display("FAIL back_to_back: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d", o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    int p0;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    p0 = we_pulses;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 8'h31; req_wdata = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_ready: got %b want 1", req_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (mem[12] !== 32'hBEEFAA44 || we_pulses != p0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_abandon: got word=%h pulses=%0d rv=%b want beefaa44 pulses=0 rv=0", mem[12], we_pulses - p0, resp_valid);
    end
    lsu_op(1'b0, 2'b00, 1'b0, 8'h30, 32'h0, 1'b0, 32'hBEEFAA44, 3);
    while (exp_q.size() != 0) begin
      resp_t e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      vectors++;
      if ({o.err, o.rdata, o.lat} !== {e.err, e.rdata, e.lat}) begin
        miscompares++;
        $display("FAIL rst_reload: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d", o.err, o.rdata, o.lat, e.err, e.rdata, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_load();
    test_half_load();
    test_subword_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
